// File: rtl/polyvec_acc_collector.sv
// polyvec_acc_collector
//   Collects coefficient pairs from the polyvec_basemul_acc_mont output stream.
//   Pairs may arrive in any order. Each pair is stored in a 2^(DEPTH-1) x 32 buffer,
//   and a bitmap records which slots have been written. When every slot is written,
//   or when the accumulator pulses in_done, the buffer is drained in ascending index
//   order over a valid/ready interface. The block then re-arms for the next polynomial.
//
// Ports
//   clk                 clock; all state changes on the rising edge
//   reset               asynchronous, active-low reset
//   din_valid           input pair valid this cycle
//   polyvec_din_1/2     coefficients at in_index / in_index+1
//   in_index            even coefficient index of the input pair
//   in_done             one-cycle pulse: the accumulator has finished this polynomial
//   readout             high while collecting (accepting input pairs)
//   dout_valid/ready    drain handshake
//   dout_1/2            drained coefficients; slots never written read as 0
//   dout_index          even coefficient index of the drained pair
//   full                every pair slot has been written
//   incomplete          the current drain was started by in_done with slots missing
//   err                 sticky: a pair was dropped or an odd in_index was seen
module polyvec_acc_collector #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [15:0]      polyvec_din_1,
  input  logic [15:0]      polyvec_din_2,
  input  logic [DEPTH-1:0] in_index,
  input  logic             in_done,
  output logic             readout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [15:0]      dout_1,
  output logic [15:0]      dout_2,
  output logic [DEPTH-1:0] dout_index,
  output logic             full,
  output logic             incomplete,
  output logic             err
);

  localparam int AW     = DEPTH - 1;
  localparam int NPAIRS = 1 << AW;
  localparam logic [DEPTH-1:0] LAST_CNT = DEPTH'(NPAIRS - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t            state_q;
  logic [NPAIRS-1:0] written_q;
  logic [DEPTH-1:0]  count_q;
  logic [AW-1:0]     ptr_q;
  logic              dout_valid_q;
  logic              full_q;
  logic              incomplete_q;
  logic              err_q;
  logic              rd_written_q;
  logic [31:0]       rd_data_q;
  logic [31:0]       mem [NPAIRS];

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_d;
  logic          wr_en;
  logic          new_slot;
  logic          fill_done;
  logic          accept;
  logic          last_beat;

  assign wr_addr   = in_index[DEPTH-1:1];
  assign wr_en     = (state_q == COLLECT) && din_valid;
  assign new_slot  = wr_en && !written_q[wr_addr];
  assign fill_done = new_slot && (count_q == LAST_CNT);
  assign accept    = dout_valid_q && dout_ready;
  assign last_beat = accept && (ptr_q == '1);

  // Read ahead: when the current pair is accepted, start reading the next slot in the
  // same cycle so that the following beat is ready without a bubble. While stalled,
  // the same slot is re-read. The buffer is frozen during a drain, so the data stays stable.
  assign rd_addr_d = (accept && !last_beat) ? ptr_q + 1'b1 : ptr_q;

  // Buffer storage: no reset, registered read. Stale contents are masked by the bitmap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {polyvec_din_1, polyvec_din_2};
    end
    rd_data_q <= mem[rd_addr_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= COLLECT;
      written_q    <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      dout_valid_q <= 1'b0;
      full_q       <= 1'b0;
      incomplete_q <= 1'b0;
      err_q        <= 1'b0;
      rd_written_q <= 1'b0;
    end else begin
      rd_written_q <= written_q[rd_addr_d];
      case (state_q)
        COLLECT: begin
          if (wr_en) begin
            written_q[wr_addr] <= 1'b1;
            if (new_slot) begin
              count_q <= count_q + 1'b1;
            end
            if (in_index[0]) begin
              err_q <= 1'b1;
            end
          end
          // A write in the same cycle as in_done is counted before deciding
          // whether the drain is complete or incomplete.
          if (fill_done) begin
            state_q      <= DRAIN;
            full_q       <= 1'b1;
            incomplete_q <= 1'b0;
          end else if (in_done) begin
            state_q      <= DRAIN;
            incomplete_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (din_valid) begin
            err_q <= 1'b1;
          end
          // ptr_q is 0 on entry. The first beat appears once the final write
          // has become visible to the registered read.
          if (!dout_valid_q) begin
            dout_valid_q <= 1'b1;
          end else if (last_beat) begin
            dout_valid_q <= 1'b0;
            ptr_q        <= '0;
            written_q    <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            incomplete_q <= 1'b0;
            state_q      <= COLLECT;
          end else if (accept) begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  logic show_data;
  assign show_data  = dout_valid_q && rd_written_q;
  assign readout    = (state_q == COLLECT);
  assign dout_valid = dout_valid_q;
  assign dout_1     = show_data ? rd_data_q[31:16] : 16'h0000;
  assign dout_2     = show_data ? rd_data_q[15:0]  : 16'h0000;
  assign dout_index = {ptr_q, 1'b0};
  assign full       = full_q;
  assign incomplete = incomplete_q;
  assign err        = err_q;

endmodule

// File: tb/tb_polyvec_acc_collector.sv
module tb_polyvec_acc_collector;

  localparam int DEPTH = 8;
  localparam int NP    = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic             din_valid;
  logic [15:0]      polyvec_din_1;
  logic [15:0]      polyvec_din_2;
  logic [DEPTH-1:0] in_index;
  logic             in_done;
  logic             readout;
  logic             dout_valid;
  logic             dout_ready;
  logic [15:0]      dout_1;
  logic [15:0]      dout_2;
  logic [DEPTH-1:0] dout_index;
  logic             full;
  logic             incomplete;
  logic             err;

  polyvec_acc_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid),
    .polyvec_din_1(polyvec_din_1), .polyvec_din_2(polyvec_din_2),
    .in_index(in_index), .in_done(in_done), .readout(readout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_1(dout_1), .dout_2(dout_2), .dout_index(dout_index),
    .full(full), .incomplete(incomplete), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one entry per pair slot, plus the collector's visible status.
  logic [15:0] m_d1 [NP];
  logic [15:0] m_d2 [NP];
  bit          m_wr [NP];
  int          m_cnt;
  bit          m_collect;
  bit          m_incomplete;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) m_wr[i] = 1'b0;
    m_cnt = 0;
    m_collect = 1'b1;
    m_incomplete = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_readout"}, readout, 1);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout_1"}, dout_1, 0);
    chk({tag, "_dout_2"}, dout_2, 0);
    chk({tag, "_dout_index"}, dout_index, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_incomplete"}, incomplete, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Apply one input pair (optionally with in_done), update the model, and check status.
  task automatic write_pair(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input bit done);
    int s;
    din_valid = 1'b1;
    in_index = idx[DEPTH-1:0];
    polyvec_din_1 = a;
    polyvec_din_2 = b;
    in_done = done;
    step();
    din_valid = 1'b0;
    in_done = 1'b0;
    if (m_collect) begin
      s = idx / 2;
      m_d1[s] = a;
      m_d2[s] = b;
      if (!m_wr[s]) begin
        m_wr[s] = 1'b1;
        m_cnt++;
      end
      if ((idx % 2) != 0) m_err = 1'b1;
      if (m_cnt == NP) begin
        m_collect = 1'b0;
        m_incomplete = 1'b0;
      end else if (done) begin
        m_collect = 1'b0;
        m_incomplete = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end
    chk("wr_readout", readout, m_collect);
    chk("wr_full", full, (!m_collect && !m_incomplete));
    chk("wr_incomplete", incomplete, m_incomplete);
    chk("wr_err", err, m_err);
  endtask

  // Called 1 time unit after the edge that entered DRAIN.
  task automatic drain(input bit toggle, input bit inject, input int abort_beat);
    int k;
    int cyc;
    chk("drain_entry_valid", dout_valid, 0);
    dout_ready = 1'b0;
    if (inject) begin
      din_valid = 1'b1;
      in_index = 8'd8;
      polyvec_din_1 = 16'hDEAD;
      polyvec_din_2 = 16'hBEEF;
      in_done = 1'b1;
      m_err = 1'b1;
    end
    step();
    din_valid = 1'b0;
    in_done = 1'b0;
    if (inject) begin
      chk("inject_err", err, 1);
      chk("inject_readout", readout, 0);
      chk("inject_incomplete", incomplete, m_incomplete);
    end
    k = 0;
    cyc = 0;
    while (k < NP && cyc < 600) begin
      if (k == abort_beat) begin
        reset = 1'b0;
        #1;
        m_err = 1'b0;
        model_clear();
        check_reset_vals("abort");
        #2;
        reset = 1'b1;
        dout_ready = 1'b0;
        step();
        check_reset_vals("post_abort");
        return;
      end
      dout_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      chk("beat_valid", dout_valid, 1);
      chk("beat_index", dout_index, 2 * k);
      chk("beat_d1", dout_1, m_wr[k] ? m_d1[k] : 16'h0000);
      chk("beat_d2", dout_2, m_wr[k] ? m_d2[k] : 16'h0000);
      $display("beat idx=%0d ready=%0b d1=%04h d2=%04h", dout_index, dout_ready, dout_1, dout_2);
      if (dout_ready && dout_valid) k++;
      step();
      cyc++;
    end
    chk("drain_cycles", cyc, toggle ? 2 * NP : NP);
    dout_ready = 1'b0;
    chk("end_valid", dout_valid, 0);
    chk("end_readout", readout, 1);
    chk("end_full", full, 0);
    chk("end_incomplete", incomplete, 0);
    chk("end_err", err, m_err);
    model_clear();
  endtask

  initial begin
    int order [NP];
    int j;
    int t;
    reset = 1'b0;
    din_valid = 1'b0;
    polyvec_din_1 = '0;
    polyvec_din_2 = '0;
    in_index = '0;
    in_done = 1'b0;
    dout_ready = 1'b0;
    m_err = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
    step();
    check_reset_vals("idle");

    // 1: in-order fill with index-valued data
    for (int i = 0; i < NP; i++) write_pair(2 * i, 16'(2 * i), 16'(2 * i + 1), 1'b0);
    drain(1'b0, 1'b0, -1);

    // 2: reverse order with a rewrite of index 10 before the final pair
    for (int i = NP - 1; i >= 1; i--) write_pair(2 * i, 16'($urandom()), 16'($urandom()), 1'b0);
    write_pair(10, 16'hAAAA, 16'hAAAA, 1'b0);
    write_pair(0, 16'($urandom()), 16'($urandom()), 1'b0);
    drain(1'b0, 1'b0, -1);

    // 3: partial fill; in_done arrives together with the last write
    for (int i = 0; i < 31; i++) write_pair(2 * i, 16'($urandom()), 16'($urandom()), 1'b0);
    write_pair(62, 16'($urandom()), 16'($urandom()), 1'b1);
    drain(1'b0, 1'b0, -1);

    // 4: shuffled fill, drain with dout_ready toggling every cycle
    for (int i = 0; i < NP; i++) order[i] = i;
    for (int i = NP - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < NP; i++) write_pair(2 * order[i], 16'($urandom()), 16'($urandom()), 1'b0);
    drain(1'b1, 1'b0, -1);

    // 5: a write and in_done arriving during DRAIN are dropped and set err
    for (int i = 0; i < NP; i++) write_pair(2 * i, 16'($urandom()), 16'($urandom()), 1'b0);
    drain(1'b0, 1'b1, -1);

    // 6: reset at drain beat 40, then refill starting with an odd index
    for (int i = 0; i < NP; i++) write_pair(2 * i, 16'($urandom()), 16'($urandom()), 1'b0);
    drain(1'b0, 1'b0, 40);
    write_pair(5, 16'($urandom()), 16'($urandom()), 1'b0);
    for (int i = 0; i < NP; i++) begin
      if (i != 2) write_pair(2 * i, 16'($urandom()), 16'($urandom()), 1'b0);
    end
    drain(1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
